// File: rtl/multi_port_queue_pkg.sv
// -----------------------------------------------------------------------------
// multi_port_queue_pkg
//   Shared defaults for the multi-lane instruction queue. The pointer and count
//   widths are derived inside the queue itself from its parameters, so this
//   package only carries the default parameterisation used across the codebase.
// -----------------------------------------------------------------------------
package multi_port_queue_pkg;

   localparam int MPQ_DATA_WIDTH  = 32;
   localparam int MPQ_QUEUE_DEPTH = 16;
   localparam int MPQ_WAYS        = 2;

endpackage : multi_port_queue_pkg

// File: rtl/multi_port_queue.sv
// -----------------------------------------------------------------------------
// multi_port_queue
//   Circular FIFO that accepts up to WAYS entries and releases up to WAYS
//   entries per cycle, for superscalar fetch/decode buffering. Read lanes are
//   first-word-fall-through; a single-cycle flush supports mispredict recovery.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset (priority over flush)
//   flush      discard all contents; queue is empty next cycle
//   enq_valid  per-lane write request, contiguous from lane 0
//   enq_data   per-lane write payload
//   enq_ready  at least WAYS free slots
//   deq_valid  lane i holds entry head+i
//   deq_data   entry at head+i, zero when the lane is invalid
//   deq_cnt    entries consumed this cycle (<= popcount(deq_valid))
//   count      current occupancy
//   full       count == QUEUE_DEPTH
//   empty      count == 0
//
// Handshake: a write burst transfers on a rising edge when enq_ready is high
// and enq_valid is non-zero; the burst is taken whole or not at all. enq_ready
// depends on registered occupancy only, so a same-cycle dequeue never makes
// room for a same-cycle enqueue. On the read side deq_valid is the offer and
// deq_cnt is the consumer's acceptance, counted from lane 0.
// -----------------------------------------------------------------------------
module multi_port_queue
   import multi_port_queue_pkg::*;
#(
   parameter int DATA_WIDTH  = MPQ_DATA_WIDTH,
   parameter int QUEUE_DEPTH = MPQ_QUEUE_DEPTH,
   parameter int WAYS        = MPQ_WAYS
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic [WAYS-1:0]                     enq_valid,
   input  logic [WAYS-1:0][DATA_WIDTH-1:0]     enq_data,
   output logic                                enq_ready,
   output logic [WAYS-1:0]                     deq_valid,
   output logic [WAYS-1:0][DATA_WIDTH-1:0]     deq_data,
   input  logic [$clog2(WAYS+1)-1:0]           deq_cnt,
   output logic [$clog2(QUEUE_DEPTH):0]        count,
   output logic                                full,
   output logic                                empty
);

   localparam int IW = $clog2(QUEUE_DEPTH);  // slot index width
   localparam int PW = IW + 1;               // pointer width incl. wrap bit
   localparam int DW = $clog2(WAYS + 1);     // lane-count width

   logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];

   logic [PW-1:0] head_q, tail_q;
   logic [PW-1:0] head_d, tail_d;
   logic [DW-1:0] enq_n;
   logic [DW-1:0] deq_avail;
   logic [PW-1:0] free_slots;
   logic          enq_fire;

   // Occupancy is the pointer distance; the wrap bit makes full and empty
   // distinguishable when the slot indices coincide.
   assign count      = tail_q - head_q;
   assign empty      = (head_q == tail_q);
   assign full       = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
   assign free_slots = PW'(QUEUE_DEPTH) - count;
   assign enq_ready  = (free_slots >= PW'(WAYS));
   assign deq_avail  = (count >= PW'(WAYS)) ? DW'(WAYS) : DW'(count);

   always_comb begin
      enq_n = '0;
      for (int i = 0; i < WAYS; i++) begin
         enq_n = enq_n + DW'(enq_valid[i]);
      end
   end

   assign enq_fire = enq_ready && (enq_n != '0);

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         head_d = head_q + PW'(deq_cnt);
         if (enq_fire) begin
            tail_d = tail_q + PW'(enq_n);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Storage has no reset; stale slots are never visible because the read
   // lanes are gated by occupancy. A burst may straddle the end of the array,
   // which the modulo index handles naturally.
   always_ff @(posedge clk) begin
      if (!rst && !flush && enq_fire) begin
         for (int i = 0; i < WAYS; i++) begin
            if (enq_valid[i]) begin
               mem[IW'(tail_q + PW'(i))] <= enq_data[i];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < WAYS; i++) begin
         deq_valid[i] = (count > PW'(i));
         deq_data[i]  = deq_valid[i] ? mem[IW'(head_q + PW'(i))] : '0;
      end
   end

   // Protocol checks for simulation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (deq_cnt <= deq_avail)
            else $error("multi_port_queue: deq_cnt %0d exceeds available %0d", deq_cnt, deq_avail);
         assert ((enq_valid & (enq_valid + WAYS'(1))) == '0)
            else $error("multi_port_queue: enq_valid %b not contiguous from lane 0", enq_valid);
         assert (enq_ready || (enq_valid == '0))
            else $warning("multi_port_queue: enqueue while not ready, burst dropped");
      end
   end

endmodule : multi_port_queue

// File: tb/tb_multi_port_queue.sv
// -----------------------------------------------------------------------------
// tb_multi_port_queue
//   Bench for multi_port_queue. Instance a: 32-bit, depth 8, two lanes.
//   Instance b: 32-bit, depth 4, one lane. Table records carry stimulus and the
//   expected status after the edge; payload order is checked against a
//   scoreboard queue filled when a burst is accepted.
// -----------------------------------------------------------------------------
module tb_multi_port_queue;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- instance a (depth 8, ways 2) ----------------
   logic             a_flush;
   logic [1:0]       a_enq_valid;
   logic [1:0][31:0] a_enq_data;
   logic             a_enq_ready;
   logic [1:0]       a_deq_valid;
   logic [1:0][31:0] a_deq_data;
   logic [1:0]       a_deq_cnt;
   logic [3:0]       a_count;
   logic             a_full, a_empty;

   multi_port_queue #(.DATA_WIDTH(32), .QUEUE_DEPTH(8), .WAYS(2)) dut_a (
      .clk(clk), .rst(rst), .flush(a_flush),
      .enq_valid(a_enq_valid), .enq_data(a_enq_data), .enq_ready(a_enq_ready),
      .deq_valid(a_deq_valid), .deq_data(a_deq_data), .deq_cnt(a_deq_cnt),
      .count(a_count), .full(a_full), .empty(a_empty)
   );

   // ---------------- instance b (depth 4, ways 1) ----------------
   logic             b_flush;
   logic [0:0]       b_enq_valid;
   logic [0:0][31:0] b_enq_data;
   logic             b_enq_ready;
   logic [0:0]       b_deq_valid;
   logic [0:0][31:0] b_deq_data;
   logic [0:0]       b_deq_cnt;
   logic [2:0]       b_count;
   logic             b_full, b_empty;

   multi_port_queue #(.DATA_WIDTH(32), .QUEUE_DEPTH(4), .WAYS(1)) dut_b (
      .clk(clk), .rst(rst), .flush(b_flush),
      .enq_valid(b_enq_valid), .enq_data(b_enq_data), .enq_ready(b_enq_ready),
      .deq_valid(b_deq_valid), .deq_data(b_deq_data), .deq_cnt(b_deq_cnt),
      .count(b_count), .full(b_full), .empty(b_empty)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   logic [31:0] exp_b_q[$];
   int          a_m_count = 0;
   int          b_m_count = 0;
   int          n_checks  = 0;
   int          n_fail    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sb_underflow(input string name, input int lane);
      n_checks++;
      n_fail++;
      $display("FAIL %s: lane %0d consumed but scoreboard has no entry", name, lane);
   endtask

   // ---------------- stimulus table ----------------
   typedef struct {
      logic [1:0]  ev;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  dc;
      logic        fl;
      int          e_cnt;
      logic        e_full;
      logic        e_empty;
      logic        e_ready;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] dc, input logic fl, input int e_cnt,
                      input logic e_full, input logic e_empty, input logic e_ready);
      vec_t v;
      v.ev = ev; v.d0 = d0; v.d1 = d1; v.dc = dc; v.fl = fl;
      v.e_cnt = e_cnt; v.e_full = e_full; v.e_empty = e_empty; v.e_ready = e_ready;
      tbl.push_back(v);
   endtask

   // ---------------- driver tasks ----------------
   // Called #1 after a rising edge: consumed lanes are compared against the
   // scoreboard, inputs are driven, then status is checked after the edge.
   task automatic a_step(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] dc, input logic fl, input int e_cnt,
                         input logic e_full, input logic e_empty, input logic e_ready);
      int   n;
      logic acc;
      for (int i = 0; i < 2; i++) begin
         if (i < int'(dc)) begin
            if (exp_q.size() > i) chk($sformatf("a_deq_data[%0d]", i), a_deq_data[i], exp_q[i]);
            else sb_underflow("a_deq_data", i);
         end
      end
      a_enq_valid   = ev;
      a_enq_data[0] = d0;
      a_enq_data[1] = d1;
      a_deq_cnt     = dc;
      a_flush       = fl;
      n   = int'(ev[0]) + int'(ev[1]);
      acc = !fl && (n > 0) && ((8 - a_m_count) >= 2);
      @(posedge clk);
      #1;
      if (fl) begin
         exp_q.delete();
         a_m_count = 0;
      end else begin
         repeat (int'(dc)) void'(exp_q.pop_front());
         if (acc && ev[0]) exp_q.push_back(d0);
         if (acc && ev[1]) exp_q.push_back(d1);
         a_m_count = a_m_count + (acc ? n : 0) - int'(dc);
      end
      a_enq_valid = '0;
      a_deq_cnt   = '0;
      a_flush     = 1'b0;
      chk("a_count", 32'(a_count), 32'(e_cnt));
      chk("a_full", 32'(a_full), 32'(e_full));
      chk("a_empty", 32'(a_empty), 32'(e_empty));
      chk("a_enq_ready", 32'(a_enq_ready), 32'(e_ready));
      chk("a_deq_valid", 32'(a_deq_valid), {30'd0, a_m_count > 1, a_m_count > 0});
      for (int i = 0; i < 2; i++) begin
         if (i >= a_m_count) chk($sformatf("a_deq_data_idle[%0d]", i), a_deq_data[i], 32'd0);
      end
   endtask

   task automatic b_step(input logic ev, input logic [31:0] d, input logic dc, input int e_cnt,
                         input logic e_full, input logic e_empty, input logic e_ready);
      logic acc;
      if (dc) begin
         if (exp_b_q.size() > 0) chk("b_deq_data", b_deq_data[0], exp_b_q[0]);
         else sb_underflow("b_deq_data", 0);
      end
      b_enq_valid   = ev;
      b_enq_data[0] = d;
      b_deq_cnt     = dc;
      acc = ev && ((4 - b_m_count) >= 1);
      @(posedge clk);
      #1;
      if (dc) void'(exp_b_q.pop_front());
      if (acc) exp_b_q.push_back(d);
      b_m_count = b_m_count + (acc ? 1 : 0) - int'(dc);
      b_enq_valid = '0;
      b_deq_cnt   = '0;
      chk("b_count", 32'(b_count), 32'(e_cnt));
      chk("b_full", 32'(b_full), 32'(e_full));
      chk("b_empty", 32'(b_empty), 32'(e_empty));
      chk("b_enq_ready", 32'(b_enq_ready), 32'(e_ready));
      chk("b_deq_valid", 32'(b_deq_valid), 32'(b_m_count > 0));
      if (b_m_count == 0) chk("b_deq_data_idle", b_deq_data[0], 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int split;
      a_flush = 1'b0; a_enq_valid = '0; a_enq_data = '0; a_deq_cnt = '0;
      b_flush = 1'b0; b_enq_valid = '0; b_enq_data = '0; b_deq_cnt = '0;

      // Fill with 1..8, drop an overflow burst, drain in pairs.
      add(2'b11, 32'd1, 32'd2, 2'd0, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      add(2'b11, 32'd3, 32'd4, 2'd0, 1'b0, 4, 1'b0, 1'b0, 1'b1);
      add(2'b11, 32'd5, 32'd6, 2'd0, 1'b0, 6, 1'b0, 1'b0, 1'b1);
      add(2'b11, 32'd7, 32'd8, 2'd0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
      add(2'b11, 32'hDEAD, 32'hBEEF, 2'd0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
      add(2'b00, 32'd0, 32'd0, 2'd2, 1'b0, 6, 1'b0, 1'b0, 1'b1);
      add(2'b00, 32'd0, 32'd0, 2'd2, 1'b0, 4, 1'b0, 1'b0, 1'b1);
      add(2'b00, 32'd0, 32'd0, 2'd2, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      add(2'b00, 32'd0, 32'd0, 2'd2, 1'b0, 0, 1'b0, 1'b1, 1'b1);
      split = tbl.size();
      // Single-lane fill near full, then flush with colliding enq/deq.
      add(2'b11, 32'hC1, 32'hC2, 2'd0, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      add(2'b11, 32'hC3, 32'hC4, 2'd0, 1'b0, 4, 1'b0, 1'b0, 1'b1);
      add(2'b11, 32'hC5, 32'hC6, 2'd0, 1'b0, 6, 1'b0, 1'b0, 1'b1);
      add(2'b01, 32'hC7, 32'h0,  2'd0, 1'b0, 7, 1'b0, 1'b0, 1'b0);
      add(2'b01, 32'hCC, 32'h0,  2'd0, 1'b0, 7, 1'b0, 1'b0, 1'b0);
      add(2'b00, 32'h0,  32'h0,  2'd1, 1'b0, 6, 1'b0, 1'b0, 1'b1);
      add(2'b01, 32'hC8, 32'h0,  2'd0, 1'b0, 7, 1'b0, 1'b0, 1'b0);
      add(2'b00, 32'h0,  32'h0,  2'd2, 1'b0, 5, 1'b0, 1'b0, 1'b1);
      add(2'b11, 32'hD0, 32'hE0, 2'd1, 1'b1, 0, 1'b0, 1'b1, 1'b1);
      add(2'b11, 32'hF0, 32'hF1, 2'd0, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      add(2'b00, 32'h0,  32'h0,  2'd2, 1'b0, 0, 1'b0, 1'b1, 1'b1);

      // Reset
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("a_rst_count", 32'(a_count), 32'd0);
      chk("a_rst_empty", 32'(a_empty), 32'd1);
      chk("a_rst_full", 32'(a_full), 32'd0);
      chk("a_rst_enq_ready", 32'(a_enq_ready), 32'd1);
      chk("a_rst_deq_valid", 32'(a_deq_valid), 32'd0);
      chk("a_rst_deq_data0", a_deq_data[0], 32'd0);
      chk("a_rst_deq_data1", a_deq_data[1], 32'd0);
      chk("b_rst_count", 32'(b_count), 32'd0);
      chk("b_rst_empty", 32'(b_empty), 32'd1);
      chk("b_rst_enq_ready", 32'(b_enq_ready), 32'd1);

      // Idle cycle keeps reset state
      a_step(2'b00, 32'd0, 32'd0, 2'd0, 1'b0, 0, 1'b0, 1'b1, 1'b1);

      for (int k = 0; k < split; k++) begin
         a_step(tbl[k].ev, tbl[k].d0, tbl[k].d1, tbl[k].dc, tbl[k].fl,
                tbl[k].e_cnt, tbl[k].e_full, tbl[k].e_empty, tbl[k].e_ready);
      end

      // Steady state at count 4 with wrapping pointers.
      a_step(2'b11, $urandom, $urandom, 2'd0, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      a_step(2'b11, $urandom, $urandom, 2'd0, 1'b0, 4, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 20; k++) begin
         a_step(2'b11, $urandom, $urandom, 2'd2, 1'b0, 4, 1'b0, 1'b0, 1'b1);
      end
      a_step(2'b00, 32'd0, 32'd0, 2'd2, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      a_step(2'b00, 32'd0, 32'd0, 2'd2, 1'b0, 0, 1'b0, 1'b1, 1'b1);

      for (int k = split; k < tbl.size(); k++) begin
         a_step(tbl[k].ev, tbl[k].d0, tbl[k].d1, tbl[k].dc, tbl[k].fl,
                tbl[k].e_cnt, tbl[k].e_full, tbl[k].e_empty, tbl[k].e_ready);
      end

      // Single-lane queue: plain FIFO, enq+deq below full and at full.
      b_step(1'b1, 32'h101, 1'b0, 1, 1'b0, 1'b0, 1'b1);
      b_step(1'b1, 32'h102, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      b_step(1'b1, 32'h103, 1'b0, 3, 1'b0, 1'b0, 1'b1);
      b_step(1'b1, 32'h104, 1'b1, 3, 1'b0, 1'b0, 1'b1);
      b_step(1'b1, 32'h105, 1'b0, 4, 1'b1, 1'b0, 1'b0);
      b_step(1'b1, 32'h1FF, 1'b1, 3, 1'b0, 1'b0, 1'b1);
      b_step(1'b0, 32'h0,   1'b1, 2, 1'b0, 1'b0, 1'b1);
      b_step(1'b0, 32'h0,   1'b1, 1, 1'b0, 1'b0, 1'b1);
      b_step(1'b0, 32'h0,   1'b1, 0, 1'b0, 1'b1, 1'b1);

      // Reset arriving with a burst discards it.
      a_step(2'b11, 32'h51, 32'h52, 2'd0, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      a_enq_valid   = 2'b11;
      a_enq_data[0] = 32'h53;
      a_enq_data[1] = 32'h54;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      a_enq_valid = '0;
      exp_q.delete();
      a_m_count = 0;
      chk("a_midrst_count", 32'(a_count), 32'd0);
      chk("a_midrst_empty", 32'(a_empty), 32'd1);
      chk("a_midrst_deq_valid", 32'(a_deq_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_multi_port_queue
